parking_gate_arbiter: RTL and testbench

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

---
 rtl/parking_gate_arbiter.sv | 144 ++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Parking gate arbiter: one shared barrier serving an entry lane and an exit lane.
// A lane is granted from IDLE, the gate stays raised while the car approaches
// (WAIT_CAR) and passes (PASSING), then the FSM holds in RELEASE until the
// served lane drops its request. The occupancy count is updated when a car
// finishes passing. If no car arrives within TIMEOUT cycles, the grant is aborted.
//
// Handshake note: entry_req/exit_req are level requests sampled only in IDLE
// (entry only while not full). A grant, once issued, holds until the car clears
// the barrier or the wait times out. The lane may issue a new request only after
// it has dropped its level once in RELEASE.
module parking_gate_arbiter #(
    parameter int CAPACITY = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass_sensor,
    output logic       gate_open,
    output logic       entry_grant,
    output logic       exit_grant,
    output logic [7:0] occupancy,
    output logic       full,
    output logic       timeout_err,
    output logic [1:0] dbg_state
);

    localparam int         TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0] CAP_V   = 8'(CAPACITY);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CAR = 2'd1,
        PASSING  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_occupancy;
    logic          r_gate_open;
    logic          r_entry_grant;
    logic          r_exit_grant;
    logic          r_timeout_err;
    logic          r_last_exit;   // lane served most recently (1 = exit)
    logic          r_lane_exit;   // lane currently owning the gate (1 = exit)

    logic w_full;
    logic w_entry_ok;
    logic w_exit_ok;
    logic w_pick_exit;
    logic w_lane_req;

    // Lane eligibility and fair pick: on a tie, the lane not served last wins
    always_comb begin
        w_full      = (r_occupancy == CAP_V);
        w_entry_ok  = entry_req && !w_full;
        w_exit_ok   = exit_req;
        w_pick_exit = w_exit_ok && (!w_entry_ok || !r_last_exit);
        w_lane_req  = r_lane_exit ? exit_req : entry_req;
    end

    // Gate FSM with registered grant/gate/error outputs and occupancy counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_occupancy   <= '0;
            r_gate_open   <= 1'b0;
            r_entry_grant <= 1'b0;
            r_exit_grant  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_last_exit   <= 1'b0;
            r_lane_exit   <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_entry_ok || w_exit_ok) begin
                        r_state       <= WAIT_CAR;
                        r_timer       <= '0;
                        r_gate_open   <= 1'b1;
                        r_entry_grant <= !w_pick_exit;
                        r_exit_grant  <= w_pick_exit;
                        r_lane_exit   <= w_pick_exit;
                        r_last_exit   <= w_pick_exit;
                    end
                end
                WAIT_CAR: begin
                    if (pass_sensor) begin
                        r_state <= PASSING;
                        r_timer <= '0;
                    end else if (r_timer == T_LAST) begin
                        // No car arrived: abort the grant without counting
                        r_state       <= RELEASE;
                        r_timer       <= '0;
                        r_gate_open   <= 1'b0;
                        r_entry_grant <= 1'b0;
                        r_exit_grant  <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                PASSING: begin
                    if (!pass_sensor) begin
                        r_state       <= RELEASE;
                        r_gate_open   <= 1'b0;
                        r_entry_grant <= 1'b0;
                        r_exit_grant  <= 1'b0;
                        if (r_lane_exit) begin
                            if (r_occupancy != 8'd0) begin
                                r_occupancy <= r_occupancy - 8'd1;
                            end
                        end else begin
                            if (r_occupancy < CAP_V) begin
                                r_occupancy <= r_occupancy + 8'd1;
                            end
                        end
                    end
                end
                RELEASE: begin
                    if (!w_lane_req) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gate_open   = r_gate_open;
    assign entry_grant = r_entry_grant;
    assign exit_grant  = r_exit_grant;
    assign occupancy   = r_occupancy;
    assign full        = w_full;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter (CAPACITY=8, TIMEOUT=64).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_parking_gate_arbiter;

    localparam int CAP  = 8;
    localparam int TOUT = 64;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_REL  = 2'd3;

    logic       clk;
    logic       reset;
    logic       entry_req;
    logic       exit_req;
    logic       pass_sensor;
    logic       gate_open;
    logic       entry_grant;
    logic       exit_grant;
    logic [7:0] occupancy;
    logic       full;
    logic       timeout_err;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // {timeout_expected, lane_is_exit, occupancy_after}
    logic [9:0] exp_q[$];
    int         model_occ = 0;
    int         occ_before = 0;
    logic       seen_lane_exit = 1'b0;
    logic [1:0] prev_state = 2'd0;

    parking_gate_arbiter #(.CAPACITY(CAP), .TIMEOUT(TOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .pass_sensor (pass_sensor),
        .gate_open   (gate_open),
        .entry_grant (entry_grant),
        .exit_grant  (exit_grant),
        .occupancy   (occupancy),
        .full        (full),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Every entry into RELEASE ends one transaction: pop and compare.
    always @(negedge clk) begin
        logic [9:0] e;
        if (entry_grant) seen_lane_exit = 1'b0;
        if (exit_grant)  seen_lane_exit = 1'b1;
        if (!reset && dbg_state == S_REL && prev_state != S_REL) begin
            if (exp_q.size() == 0) begin
                check("unexpected_release", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_occupancy", occupancy, e[7:0]);
                check("sb_timeout_err", timeout_err, e[9]);
                check("sb_lane", seen_lane_exit, e[8]);
            end
        end
        prev_state = reset ? S_IDLE : dbg_state;
    end

    // ---------------- driver tasks ----------------
    task automatic expect_txn(input bit is_exit, input bit is_timeout);
        occ_before = model_occ;
        if (!is_timeout) begin
            if (is_exit) model_occ = (model_occ > 0) ? model_occ - 1 : 0;
            else         model_occ = (model_occ < CAP) ? model_occ + 1 : CAP;
        end
        exp_q.push_back({is_timeout, is_exit, 8'(model_occ)});
    endtask

    // Grant must be visible one clock after the request is seen in IDLE
    task automatic wait_grant(input bit is_exit);
        @(negedge clk);
        check(is_exit ? "exit_grant" : "entry_grant", is_exit ? exit_grant : entry_grant, 1);
        check("other_grant_low", is_exit ? entry_grant : exit_grant, 0);
        check("gate_open_on_grant", gate_open, 1);
        check("state_wait", dbg_state, S_WAIT);
    endtask

    task automatic pass_car(input int hold);
        pass_sensor = 1'b1;
        for (int i = 0; i < hold; i++) @(negedge clk);
        check("state_passing", dbg_state, S_PASS);
        check("gate_open_passing", gate_open, 1);
        check("occ_before_fall", occupancy, occ_before);
        pass_sensor = 1'b0;
        @(negedge clk);
        check("state_release", dbg_state, S_REL);
    endtask

    task automatic finish_lane(input bit is_exit, input int linger);
        for (int i = 0; i < linger; i++) begin
            @(negedge clk);
            check("release_hold", dbg_state, S_REL);
            check("release_gate", gate_open, 0);
            check("release_grants", {entry_grant, exit_grant}, 0);
        end
        if (is_exit) exit_req = 1'b0;
        else         entry_req = 1'b0;
        @(negedge clk);
        check("back_to_idle", dbg_state, S_IDLE);
    endtask

    task automatic single_txn(input bit is_exit, input int hold);
        if (is_exit) exit_req = 1'b1;
        else         entry_req = 1'b1;
        expect_txn(is_exit, 1'b0);
        wait_grant(is_exit);
        pass_car(hold);
        finish_lane(is_exit, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        reset = 1'b1;
        entry_req = 1'b0;
        exit_req = 1'b0;
        pass_sensor = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gate", gate_open, 0);
        check("rst_grants", {entry_grant, exit_grant}, 0);
        check("rst_occ", occupancy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_state", dbg_state, S_IDLE);
        reset = 1'b0;
        @(negedge clk);

        // Both lanes from reset: exit first (pass at 0 saturates), then entry
        entry_req = 1'b1;
        exit_req  = 1'b1;
        expect_txn(1'b1, 1'b0);
        wait_grant(1'b1);
        pass_car(3);
        check("occ_zero_sat", occupancy, 0);
        check("no_err_sat", timeout_err, 0);
        finish_lane(1'b1, 1);
        expect_txn(1'b0, 1'b0);
        wait_grant(1'b0);
        // Entry car under the barrier for 5 cycles, RELEASE held until entry_req drops
        pass_car(5);
        check("occ_first_entry", occupancy, 1);
        finish_lane(1'b0, 3);

        // Build to 3, then a tie: exit wins (entry served last), then entry
        single_txn(1'b0, 2);
        single_txn(1'b0, 1);
        check("occ_three", occupancy, 3);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        expect_txn(1'b1, 1'b0);
        wait_grant(1'b1);
        pass_car(2);
        check("occ_tie_exit", occupancy, 2);
        finish_lane(1'b1, 1);
        expect_txn(1'b0, 1'b0);
        wait_grant(1'b0);
        pass_car(2);
        check("occ_tie_entry", occupancy, 3);
        finish_lane(1'b0, 1);

        // Fill to capacity
        for (int i = 0; i < 5; i++) single_txn(1'b0, $urandom_range(1, 4));
        check("occ_full", occupancy, CAP);
        check("full_flag", full, 1);

        // Entry blocked while full; exit then frees a slot and entry follows
        entry_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("blocked_grants", {entry_grant, exit_grant}, 0);
            check("blocked_gate", gate_open, 0);
            check("blocked_full", full, 1);
        end
        exit_req = 1'b1;
        expect_txn(1'b1, 1'b0);
        wait_grant(1'b1);
        pass_car(2);
        check("occ_after_exit", occupancy, CAP - 1);
        check("not_full", full, 0);
        finish_lane(1'b1, 1);
        expect_txn(1'b0, 1'b0);
        wait_grant(1'b0);
        pass_car(2);
        finish_lane(1'b0, 1);
        check("refull", full, 1);

        // Exit timeout: gate open exactly TIMEOUT cycles, one-cycle error pulse
        exit_req = 1'b1;
        expect_txn(1'b1, 1'b1);
        wait_grant(1'b1);
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!gate_open) break;
            cnt++;
        end
        check("timeout_gate_cycles", cnt, TOUT);
        check("timeout_pulse", timeout_err, 1);
        check("timeout_occ", occupancy, CAP);
        @(negedge clk);
        check("timeout_pulse_end", timeout_err, 0);
        check("timeout_release", dbg_state, S_REL);
        exit_req = 1'b0;
        @(negedge clk);
        check("timeout_idle", dbg_state, S_IDLE);

        // Reset while PASSING: asynchronous clear, IDLE after release
        exit_req = 1'b1;
        wait_grant(1'b1);
        pass_sensor = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_reset_pass", dbg_state, S_PASS);
        #2 reset = 1'b1;
        #1;
        check("async_gate", gate_open, 0);
        check("async_grants", {entry_grant, exit_grant}, 0);
        check("async_occ", occupancy, 0);
        check("async_state", dbg_state, S_IDLE);
        @(negedge clk);
        reset = 1'b0;
        exit_req = 1'b0;
        pass_sensor = 1'b0;
        model_occ = 0;
        @(negedge clk);
        check("post_reset_idle", dbg_state, S_IDLE);
        check("post_reset_occ", occupancy, 0);
        check("post_reset_gate", gate_open, 0);

        // Random single-lane traffic against the occupancy model
        for (int i = 0; i < 8; i++) begin
            bit ex;
            ex = 1'($urandom_range(0, 1));
            single_txn(ex, $urandom_range(1, 4));
            check("rand_occ", occupancy, model_occ);
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
